// File: rtl/mmio_timer_cmp_if.sv
// Bus-side signals of the MMIO uptime timer: one-cycle access strobe,
// write data, registered read data and the level interrupt.
interface mmio_timer_cmp_if;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (output sel, we, addr, din, input dout, irq);
    modport slave  (input sel, we, addr, din, output dout, irq);
endinterface

// File: rtl/mmio_timer_cmp.sv
// Memory-mapped free-running uptime timer. A prescaler produces a tick
// clock-enable every DIV bus cycles; the counter advances on each tick and
// NUM_CMP compare channels latch pending bits that drive a level interrupt.
// Reading COUNT_LO snapshots the upper counter bits so that a following
// COUNT_HI read is coherent with it.
module mmio_timer_cmp #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1_000_000,
    parameter int CNT_W   = 64,
    parameter int NUM_CMP = 2
) (
    input  logic            clock,
    input  logic            reset,
    mmio_timer_cmp_if.slave bus
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HI_W  = CNT_W - 32;

    localparam logic [7:0] OFF_COUNT_LO = 8'h00;
    localparam logic [7:0] OFF_COUNT_HI = 8'h04;
    localparam logic [7:0] OFF_CTRL     = 8'h08;
    localparam logic [7:0] OFF_STATUS   = 8'h0C;

    function automatic logic [7:0] cmp_lo_off(input int i);
        return 8'(16 + 8 * i);
    endfunction

    function automatic logic [7:0] cmp_hi_off(input int i);
        return 8'(20 + 8 * i);
    endfunction

    logic [CNT_W-1:0]   count_q, count_d;
    logic [HI_W-1:0]    hi_shadow_q, hi_shadow_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               enable_q, enable_d;
    logic [NUM_CMP-1:0] irq_en_q, irq_en_d;
    logic [NUM_CMP-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   cmp_q [NUM_CMP];
    logic [CNT_W-1:0]   cmp_d [NUM_CMP];
    logic [31:0]        dout_q, dout_d;
    logic               irq_q, irq_d;

    logic [7:0]         off;
    logic               wr, rd, wr_ctrl, wr_status, clear, tick, tick_eff;
    logic [CNT_W-1:0]   count_inc;
    logic [31:0]        rdata;
    logic               unused_addr_bits;

    assign off       = bus.addr[7:0];
    assign wr        = bus.sel & bus.we;
    assign rd        = bus.sel & ~bus.we;
    assign wr_ctrl   = wr && (off == OFF_CTRL);
    assign wr_status = wr && (off == OFF_STATUS);
    assign clear     = wr_ctrl && bus.din[1];
    assign tick      = enable_q && (pre_q == PRE_W'(DIV - 1));
    // A clear in the same cycle swallows the tick, including its compare match.
    assign tick_eff  = tick && !clear;
    assign count_inc = count_q + CNT_W'(1);

    // Only the low byte of the address is decoded.
    assign unused_addr_bits = ^bus.addr[31:8];

    // Next-state logic: prescaler, counter, control, pending bits and compare values.
    always_comb begin
        // NOTE: every variable gets its default first, so no path through
        // the block can leave a value unassigned and infer a latch.
        pre_d       = pre_q;
        count_d     = count_q;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        pending_d   = pending_q;
        cmp_d       = cmp_q;
        hi_shadow_d = hi_shadow_q;
        dout_d      = dout_q;
        irq_d       = |(pending_q & irq_en_q);

        if (clear) begin
            pre_d   = '0;
            count_d = '0;
        end else if (tick) begin
            pre_d   = '0;
            count_d = count_inc;
        end else if (enable_q) begin
            pre_d   = pre_q + PRE_W'(1);
        end

        if (wr_ctrl) begin
            enable_d = bus.din[0];
            irq_en_d = bus.din[8 +: NUM_CMP];
        end

        for (int i = 0; i < NUM_CMP; i++) begin
            // Set has priority over a same-cycle write-1-to-clear.
            pending_d[i] = (tick_eff && (count_inc == cmp_q[i]))
                         || (pending_q[i] && !(wr_status && bus.din[i]));
            if (wr && (off == cmp_lo_off(i))) cmp_d[i][31:0]       = bus.din;
            if (wr && (off == cmp_hi_off(i))) cmp_d[i][CNT_W-1:32] = bus.din[HI_W-1:0];
        end

        // The snapshot and the read data both see the pre-increment count.
        if (rd) begin
            dout_d = rdata;
            if (off == OFF_COUNT_LO) hi_shadow_d = count_q[CNT_W-1:32];
        end
    end

    // Read data multiplexer; unmapped and absent-channel offsets return zero.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_COUNT_LO: rdata = count_q[31:0];
            OFF_COUNT_HI: rdata = 32'(hi_shadow_q);
            OFF_CTRL: begin
                rdata[0]             = enable_q;
                rdata[8 +: NUM_CMP]  = irq_en_q;
            end
            OFF_STATUS:   rdata[NUM_CMP-1:0] = pending_q;
            default:      ;
        endcase
        for (int i = 0; i < NUM_CMP; i++) begin
            if (off == cmp_lo_off(i)) rdata = cmp_q[i][31:0];
            if (off == cmp_hi_off(i)) rdata = 32'(cmp_q[i][CNT_W-1:32]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values that existed before the edge.
        if (reset) begin
            count_q     <= '0;
            hi_shadow_q <= '0;
            pre_q       <= '0;
            enable_q    <= 1'b0;
            irq_en_q    <= '0;
            pending_q   <= '0;
            dout_q      <= '0;
            irq_q       <= 1'b0;
            // NOTE: the compare array is a few flops rather than a RAM, so it
            // is reset like any other register (to all-ones, i.e. far away).
            for (int i = 0; i < NUM_CMP; i++) cmp_q[i] <= '1;
        end else begin
            count_q     <= count_d;
            hi_shadow_q <= hi_shadow_d;
            pre_q       <= pre_d;
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            pending_q   <= pending_d;
            dout_q      <= dout_d;
            irq_q       <= irq_d;
            cmp_q       <= cmp_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.irq  = irq_q;
endmodule

// File: tb/tb_mmio_timer_cmp.sv
// Bench for mmio_timer_cmp. dut_a: DIV=4, 64-bit counter. dut_b: DIV=1,
// 33-bit counter (wrap and coherency near the 32-bit boundary). Expected read
// data is queued when a read is issued and compared when dout is valid.
module tb_mmio_timer_cmp;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mmio_timer_cmp_if bus_a ();
    mmio_timer_cmp_if bus_b ();

    mmio_timer_cmp #(.CLK_HZ(4), .TICK_HZ(1), .CNT_W(64), .NUM_CMP(2)) dut_a (
        .clock(clk), .reset(reset), .bus(bus_a.slave)
    );
    mmio_timer_cmp #(.CLK_HZ(1), .TICK_HZ(1), .CNT_W(33), .NUM_CMP(2)) dut_b (
        .clock(clk), .reset(reset), .bus(bus_b.slave)
    );

    always #5 clk = ~clk;

    typedef struct { string name; logic [31:0] exp; } exp_t;
    typedef struct { bit d; logic [7:0] a; logic [31:0] v; string name; } acc_t;

    exp_t sb[$];

    task automatic drive(input bit d, input logic s, input logic w,
                         input logic [7:0] a, input logic [31:0] v);
        if (d) begin
            bus_b.sel = s; bus_b.we = w; bus_b.addr = {24'h0, a}; bus_b.din = v;
        end else begin
            bus_a.sel = s; bus_a.we = w; bus_a.addr = {24'h0, a}; bus_a.din = v;
        end
    endtask

    task automatic bus_write(input bit d, input logic [7:0] a, input logic [31:0] v);
        @(negedge clk);
        drive(d, 1'b1, 1'b1, a, v);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic bus_read(input bit d, input logic [7:0] a, output logic [31:0] r);
        @(negedge clk);
        drive(d, 1'b1, 1'b0, a, 32'h0);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 8'h00, 32'h0);
        r = d ? bus_b.dout : bus_a.dout;
    endtask

    task automatic test_reset();
        acc_t t[$];
        logic [31:0] r;
        exp_t e;
        checks++; if (bus_a.irq !== 1'b0) begin errors++; $display("FAIL rst_irq_a: got %b want 0", bus_a.irq); end
        checks++; if (bus_b.irq !== 1'b0) begin errors++; $display("FAIL rst_irq_b: got %b want 0", bus_b.irq); end
        checks++; if (bus_a.dout !== 32'h0) begin errors++; $display("FAIL rst_dout_a: got 0x%08h want 0", bus_a.dout); end
        checks++; if (bus_b.dout !== 32'h0) begin errors++; $display("FAIL rst_dout_b: got 0x%08h want 0", bus_b.dout); end
        t.push_back('{1'b0, 8'h00, 32'h0000_0000, "rst_a_count_lo"});
        t.push_back('{1'b0, 8'h04, 32'h0000_0000, "rst_a_count_hi"});
        t.push_back('{1'b0, 8'h08, 32'h0000_0000, "rst_a_ctrl"});
        t.push_back('{1'b0, 8'h0C, 32'h0000_0000, "rst_a_status"});
        t.push_back('{1'b0, 8'h10, 32'hFFFF_FFFF, "rst_a_cmp0_lo"});
        t.push_back('{1'b0, 8'h14, 32'hFFFF_FFFF, "rst_a_cmp0_hi"});
        t.push_back('{1'b0, 8'h20, 32'h0000_0000, "rst_a_absent_ch2"});
        t.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, "rst_b_cmp0_lo"});
        t.push_back('{1'b1, 8'h14, 32'h0000_0001, "rst_b_cmp0_hi_33bit"});
        foreach (t[k]) sb.push_back('{t[k].name, t[k].v});
        foreach (t[k]) begin
            bus_read(t[k].d, t[k].a, r);
            e = sb.pop_front();
            checks++;
            if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        end
    endtask

    // DIV=4: enable lands at edge E, ticks at E+4k. The LO read samples at
    // E+42 (10 ticks). The disabling write lands at E+44, itself a tick edge,
    // so the frozen value is 11.
    task automatic test_rate();
        logic [31:0] r;
        exp_t e;
        bus_write(1'b0, 8'h08, 32'h1);
        repeat (40) @(negedge clk);
        sb.push_back('{"rate_count_40cyc", 32'd10});
        bus_read(1'b0, 8'h00, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, r, e.exp); end
        bus_write(1'b0, 8'h08, 32'h0);
        repeat (20) @(negedge clk);
        sb.push_back('{"rate_count_frozen", 32'd11});
        sb.push_back('{"rate_count_hi", 32'd0});
        bus_read(1'b0, 8'h00, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, r, e.exp); end
        bus_read(1'b0, 8'h04, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got %0d want %0d", e.name, r, e.exp); end
    endtask

    // CMP1=5: fifth tick at E+20 sets pending[1]; irq follows at E+21.
    task automatic test_compare();
        logic [31:0] r;
        exp_t e;
        bus_write(1'b0, 8'h08, 32'h2);
        bus_write(1'b0, 8'h18, 32'd5);
        bus_write(1'b0, 8'h1C, 32'd0);
        bus_write(1'b0, 8'h08, 32'h201);
        repeat (20) @(negedge clk);
        checks++; if (bus_a.irq !== 1'b0) begin errors++; $display("FAIL cmp_irq_lag: got %b want 0", bus_a.irq); end
        @(negedge clk);
        checks++; if (bus_a.irq !== 1'b1) begin errors++; $display("FAIL cmp_irq_set: got %b want 1", bus_a.irq); end
        sb.push_back('{"cmp_status_set", 32'h2});
        bus_read(1'b0, 8'h0C, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        bus_write(1'b0, 8'h0C, 32'h2);
        @(negedge clk);
        checks++; if (bus_a.irq !== 1'b0) begin errors++; $display("FAIL cmp_irq_w1c: got %b want 0", bus_a.irq); end
        repeat (30) @(negedge clk);
        checks++; if (bus_a.irq !== 1'b0) begin errors++; $display("FAIL cmp_no_refire_irq: got %b want 0", bus_a.irq); end
        sb.push_back('{"cmp_no_refire_status", 32'h0});
        bus_read(1'b0, 8'h0C, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
    endtask

    // Clear+enable at edge E; CMP0=3 matches at E+12 together with a W1C.
    // A second clear lands on the tick edge E+16.
    task automatic test_simultaneous();
        logic [31:0] r;
        exp_t e;
        bus_write(1'b0, 8'h10, 32'd3);
        bus_write(1'b0, 8'h14, 32'd0);
        bus_write(1'b0, 8'h08, 32'h3);
        repeat (10) @(negedge clk);
        bus_write(1'b0, 8'h0C, 32'h1);
        sb.push_back('{"sim_set_beats_w1c", 32'h1});
        bus_read(1'b0, 8'h0C, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        bus_write(1'b0, 8'h08, 32'h3);
        sb.push_back('{"sim_clear_beats_tick", 32'h0});
        sb.push_back('{"sim_ctrl_readback", 32'h1});
        bus_read(1'b0, 8'h00, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        bus_read(1'b0, 8'h08, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
    endtask

    // DIV=1 preloaded to 0xFFFFFFFD: LO read at E+3 sees 0xFFFFFFFF while the
    // counter crosses into bit 32 on that same edge; HI must still read 0.
    task automatic test_coherency();
        logic [31:0] r;
        exp_t e;
        @(negedge clk);
        force dut_b.count_q = 33'h0_FFFF_FFFD;
        @(negedge clk);
        release dut_b.count_q;
        bus_write(1'b1, 8'h08, 32'h1);
        @(negedge clk);
        sb.push_back('{"coh_lo", 32'hFFFF_FFFF});
        sb.push_back('{"coh_hi_snapshot", 32'h0});
        bus_read(1'b1, 8'h00, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        bus_read(1'b1, 8'h04, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        bus_write(1'b1, 8'h08, 32'h0);
    endtask

    // 33-bit counter from 0x1_FFFFFFFD: three ticks wrap it to 0, and the
    // pass through 0x1_FFFFFFFF matches both reset-valued compare channels.
    task automatic test_wrap();
        acc_t t[$];
        logic [31:0] r;
        exp_t e;
        @(negedge clk);
        force dut_b.count_q = 33'h1_FFFF_FFFD;
        @(negedge clk);
        release dut_b.count_q;
        sb.push_back('{"wrap_pre_lo", 32'hFFFF_FFFD});
        sb.push_back('{"wrap_pre_hi", 32'h1});
        bus_read(1'b1, 8'h00, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        bus_read(1'b1, 8'h04, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        bus_write(1'b1, 8'h08, 32'h1);
        @(negedge clk);
        bus_write(1'b1, 8'h08, 32'h0);
        bus_write(1'b1, 8'h14, 32'hFFFF_FFFE);
        bus_write(1'b1, 8'h20, 32'h1234);
        t.push_back('{1'b1, 8'h00, 32'h0000_0000, "wrap_lo"});
        t.push_back('{1'b1, 8'h04, 32'h0000_0000, "wrap_hi"});
        t.push_back('{1'b1, 8'h0C, 32'h0000_0003, "wrap_status_top_match"});
        t.push_back('{1'b1, 8'h14, 32'h0000_0000, "cmp_hi_masked"});
        t.push_back('{1'b1, 8'h10, 32'hFFFF_FFFF, "cmp_lo_kept"});
        t.push_back('{1'b1, 8'h20, 32'h0000_0000, "absent_ch_write_ignored"});
        t.push_back('{1'b1, 8'h30, 32'h0000_0000, "unmapped_read"});
        foreach (t[k]) sb.push_back('{t[k].name, t[k].v});
        foreach (t[k]) begin
            bus_read(t[k].d, t[k].a, r);
            e = sb.pop_front();
            checks++;
            if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        end
        bus_write(1'b1, 8'h08, 32'h300);
        @(negedge clk);
        checks++; if (bus_b.irq !== 1'b1) begin errors++; $display("FAIL wrap_irq_en: got %b want 1", bus_b.irq); end
        sb.push_back('{"wrap_status_again", 32'h3});
        bus_read(1'b1, 8'h0C, r);
        e = sb.pop_front(); checks++;
        if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
    endtask

    // Reset lands while both buses issue a read and dut_a is counting.
    task automatic test_reset_mid();
        acc_t t[$];
        logic [31:0] r;
        exp_t e;
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8'h08, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 8'h0C, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        checks++; if (bus_a.dout !== 32'h0) begin errors++; $display("FAIL mid_rst_dout_a: got 0x%08h want 0", bus_a.dout); end
        checks++; if (bus_b.dout !== 32'h0) begin errors++; $display("FAIL mid_rst_dout_b: got 0x%08h want 0", bus_b.dout); end
        checks++; if (bus_b.irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq_b: got %b want 0", bus_b.irq); end
        repeat (12) @(negedge clk);
        t.push_back('{1'b0, 8'h00, 32'h0000_0000, "mid_rst_a_count"});
        t.push_back('{1'b0, 8'h08, 32'h0000_0000, "mid_rst_a_ctrl"});
        t.push_back('{1'b0, 8'h10, 32'hFFFF_FFFF, "mid_rst_a_cmp0_lo"});
        t.push_back('{1'b0, 8'h18, 32'hFFFF_FFFF, "mid_rst_a_cmp1_lo"});
        t.push_back('{1'b0, 8'h1C, 32'hFFFF_FFFF, "mid_rst_a_cmp1_hi"});
        t.push_back('{1'b1, 8'h0C, 32'h0000_0000, "mid_rst_b_status"});
        t.push_back('{1'b1, 8'h14, 32'h0000_0001, "mid_rst_b_cmp0_hi"});
        t.push_back('{1'b1, 8'h08, 32'h0000_0000, "mid_rst_b_ctrl"});
        foreach (t[k]) sb.push_back('{t[k].name, t[k].v});
        foreach (t[k]) begin
            bus_read(t[k].d, t[k].a, r);
            e = sb.pop_front();
            checks++;
            if (r !== e.exp) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, r, e.exp); end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_rate();
        test_compare();
        test_simultaneous();
        test_coherency();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mmio_timer_cmp.md
Name: mmio_timer_cmp

Overview:
- Memory-mapped free-running uptime timer with programmable tick rate, NUM_CMP compare channels and a level interrupt.
- Sits on the CPU data bus beside the other MMIO peripherals and provides uptime plus alarm interrupts.
- Single clock domain: the tick is a clock-enable from an internal prescaler, not a derived clock.
- 64-bit reads are made coherent with a low-word-triggered high-word snapshot.

Parameters:
- CLK_HZ, 100000000, bus clock frequency.
- TICK_HZ, 1000000, counter increment rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥1.
- CNT_W, 64, counter width (33..64). Bits above CNT_W read as 0.
- NUM_CMP, 2, number of compare channels (1..4).

Ports:
- clock  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- sel  in  1  access strobe, one cycle per access
- we  in  1  1 = write, 0 = read; only valid with sel
- addr  in  32  byte address; only addr[7:0] is decoded
- din  in  32  write data
- dout  out  32  registered read data
- irq  out  1  level interrupt, = |(pending & irq_en)

Behaviour:
- Register map (offsets):
  - 0x00 COUNT_LO: read returns count[31:0]. The same cycle copies count[CNT_W-1:32] into hi_shadow.
  - 0x04 COUNT_HI: read returns hi_shadow, zero-extended.
  - 0x08 CTRL: bit0 enable (rw). bit1 clear (write-1 pulse, reads 0). bits[8+i] irq_en[i] (rw).
  - 0x0C STATUS: bits[i] pending[i]. Write-1-to-clear.
  - 0x10+8i CMP_LO[i], 0x14+8i CMP_HI[i]: compare value i (rw). Bits above CNT_W are ignored on write and read as 0.
  - Unmapped or absent channel offsets read 0; writes to them are ignored.
- Read timing: dout updates on the clock edge where sel=1 and we=0, so data is valid the cycle after sel. dout holds its value otherwise, including on writes.
- Writes take effect at the sel&we edge.
- Reset values: count 0, hi_shadow 0, prescaler 0, enable 0, irq_en 0, pending 0, all CMP = all-ones, dout 0, irq 0.
- Prescaler:
  - Counts 0..DIV-1 while enable=1 and holds while enable=0.
  - tick = enable & (pre == DIV-1); pre wraps to 0 on tick.
  - DIV=1 gives a tick every enabled cycle.
- Counter: increments by 1 on tick, modulo 2^CNT_W. From all-ones it wraps to 0; no flag is raised on wrap.
- Compare: on a tick where the incremented value equals CMP[i], pending[i] is set.
  - The match is evaluated against the post-increment value, so each value fires once per pass.
  - Writing CMP to the current count does not fire until the counter reaches that value again.
- Clear (CTRL bit1 written 1): count and prescaler go to 0 at that edge. A tick in the same cycle is discarded (clear wins). pending is unaffected.
- Simultaneous set and W1C of the same pending bit: set wins, and the bit stays 1.
- Same-cycle COUNT_LO read and tick: dout and hi_shadow capture the pre-increment value consistently.
- irq is registered and follows pending/irq_en one cycle later.
- reset asserted mid-operation restores all reset values on the next edge regardless of sel.

Test Plan:
- Reset, then read 0x00 and 0x04 → dout 0 both; irq 0; CMP0 reads 0xFFFFFFFF/0xFFFFFFFF.
- CLK_HZ=4, TICK_HZ=1, write CTRL=1, wait 40 cycles, read 0x00 → 10 (±1 depending on the read cycle). Write CTRL=0, wait 20 cycles → value unchanged.
- Coherency: preload the counter near 0x00000000_FFFFFFFF (clear, then DIV=1 and run). Read LO when LO=0xFFFFFFFF and the next tick lands before the HI read → HI returns 0x0, not 0x1.
- Compare channel:
  - Set CMP1=5 and CTRL=0x201 (enable, irq_en[1]).
  - After the 5th tick: STATUS=0x2, and irq=1 one cycle later.
  - Write STATUS=0x2 → irq=0.
  - No refire until the counter wraps.
- Simultaneous events: issue W1C of pending[0] in the same cycle CMP0 matches → pending[0] stays 1. Write clear in the cycle a tick is due → count reads 0.
- Wrap with CNT_W=33, DIV=1, count at 0x1_FFFFFFFF → the next tick gives 0; HI reads 0x0. Assert reset mid-count → all registers return to reset values.
